// File: rtl/alu_decode_stage_pkg.sv
// rtl/alu_decode_stage_pkg.sv - ALU op encoding, RV32I opcode/funct7 constants and funct3 op helper
package alu_decode_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } t_alu_op;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Operation selected by funct3 when funct7 is the base encoding.
   function automatic t_alu_op base_alu_op(input logic [2:0] f3);
      t_alu_op op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decode_stage_reg_file.sv
// rtl/alu_decode_stage_reg_file.sv - 32x32 register file, 2 async read ports, 1 sync write port
// FORWARD_WB_EN: same-cycle write data is bypassed onto the read ports.
module alu_decode_stage_reg_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_data,
   output logic [31:0] rs2_data,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   // x0 has no storage; it is read as zero below.
   logic [31:0] regs [1:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != 5'd0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
      rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
`ifdef FORWARD_WB_EN
      if (wr_en && (wr_addr != 5'd0) && (wr_addr == rs1_addr)) begin
         rs1_data = wr_data;
      end
      if (wr_en && (wr_addr != 5'd0) && (wr_addr == rs2_addr)) begin
         rs2_data = wr_data;
      end
`endif
   end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode into a one-entry ALU output register
// FORWARD_WB_EN (in the register file) selects same-cycle write-back bypass on operand capture.
module alu_decode_stage
   import alu_decode_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        out_valid,
   input  logic        out_ready,
   output t_alu_op     out_alu_op,
   output logic [31:0] out_alu_in1,
   output logic [31:0] out_alu_in2,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic [31:0] out_pc,
   output logic        out_illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic        accept;
   logic [31:0] pc_q;

   t_alu_op     dec_op;
   logic [31:0] dec_in1;
   logic [31:0] dec_in2;
   logic        dec_illegal;
   logic        dec_rd_we;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign rd     = in_instr[11:7];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign shamt  = {27'b0, in_instr[24:20]};

   // Reset also blocks the handshake so nothing completes in a reset cycle.
   assign in_ready = (!out_valid || out_ready) && !flush && !rst;
   assign accept   = in_valid && in_ready;
   assign out_pc   = out_valid ? pc_q : RESET_PC;

   alu_decode_stage_reg_file u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (in_instr[19:15]),
      .rs2_addr (in_instr[24:20]),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .wr_en    (wb_en),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   always_comb begin
      dec_op      = ALU_ADD;
      dec_in1     = 32'd0;
      dec_in2     = 32'd0;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_in1 = rs1_data;
            dec_in2 = rs2_data;
            if (funct7 == F7_BASE) begin
               dec_op = base_alu_op(funct3);
            end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
               dec_op = ALU_SUB;
            end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
               dec_op = ALU_SRA;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_in1 = rs1_data;
            // Shifts reuse the OP funct7 rules on instr[31:25]; other funct3 take the full immediate.
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               dec_in2 = shamt;
               if (funct7 == F7_BASE) begin
                  dec_op = base_alu_op(funct3);
               end else if ((funct7 == F7_ALT) && (funct3 == 3'b101)) begin
                  dec_op = ALU_SRA;
               end else begin
                  dec_illegal = 1'b1;
               end
            end else begin
               dec_in2 = imm_i;
               dec_op  = base_alu_op(funct3);
            end
         end
         OPC_LUI: begin
            dec_in2 = imm_u;
         end
         OPC_AUIPC: begin
            dec_in1 = in_pc;
            dec_in2 = imm_u;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
      if (dec_illegal) begin
         dec_op  = ALU_ADD;
         dec_in1 = 32'd0;
         dec_in2 = 32'd0;
      end
   end

   assign dec_rd_we = !dec_illegal && (rd != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_alu_op  <= ALU_ADD;
         out_alu_in1 <= 32'd0;
         out_alu_in2 <= 32'd0;
         out_rd      <= 5'd0;
         out_rd_we   <= 1'b0;
         out_illegal <= 1'b0;
         pc_q        <= RESET_PC;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_alu_op  <= dec_op;
         out_alu_in1 <= dec_in1;
         out_alu_in2 <= dec_in2;
         out_rd      <= rd;
         out_rd_we   <= dec_rd_we;
         out_illegal <= dec_illegal;
         pc_q        <= in_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - scoreboard bench for alu_decode_stage (honours FORWARD_WB_EN)
module tb_alu_decode_stage;
   import alu_decode_stage_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   t_alu_op     out_alu_op;
   logic [31:0] out_alu_in1;
   logic [31:0] out_alu_in2;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [31:0] out_pc;
   logic        out_illegal;

   typedef struct {
      t_alu_op     op;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        illegal;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] model_rf [32];
   t_alu_op     base_op [8];

   alu_decode_stage #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .flush       (flush),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_op  (out_alu_op),
      .out_alu_in1 (out_alu_in1),
      .out_alu_in2 (out_alu_in2),
      .out_rd      (out_rd),
      .out_rd_we   (out_rd_we),
      .out_pc      (out_pc),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      base_op = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
   end

   // Reference: architectural meaning of each supported encoding.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [6:0] f7;
      logic [2:0] f3;
      bit ok;
      f7 = ins[31:25];
      f3 = ins[14:12];
      ok = 1'b1;
      e.op = ALU_ADD; e.in1 = 32'd0; e.in2 = 32'd0; e.rd = ins[11:7]; e.pc = pc;
      case (ins[6:0])
         OPC_OP: begin
            e.in1 = a; e.in2 = b;
            if (f7 == F7_BASE) e.op = base_op[f3];
            else if (f7 == F7_ALT && f3 == 3'd0) e.op = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'd5) e.op = ALU_SRA;
            else ok = 1'b0;
         end
         OPC_OP_IMM: begin
            e.in1 = a;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.in2 = 32'(ins[24:20]);
               ok = (f7 == F7_BASE) || (f7 == F7_ALT && f3 == 3'd5);
               e.op = (f7 == F7_ALT) ? ALU_SRA : base_op[f3];
            end else begin
               e.in2 = 32'($signed(ins[31:20]));
               e.op = base_op[f3];
            end
         end
         OPC_LUI:   e.in2 = ins & 32'hFFFF_F000;
         OPC_AUIPC: begin e.in1 = pc; e.in2 = ins & 32'hFFFF_F000; end
         default:   ok = 1'b0;
      endcase
      if (!ok) begin e.op = ALU_ADD; e.in1 = 32'd0; e.in2 = 32'd0; end
      e.illegal = !ok;
      e.rd_we = ok && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] read_model(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef FORWARD_WB_EN
      if (wb_en && wb_rd == idx) return wb_data;
`endif
      return model_rf[idx];
   endfunction

   function automatic exp_t cur();
      exp_t e;
      e.op = out_alu_op; e.in1 = out_alu_in1; e.in2 = out_alu_in2; e.rd = out_rd;
      e.rd_we = out_rd_we; e.illegal = out_illegal; e.pc = out_pc;
      return e;
   endfunction

   function automatic bit same(input exp_t x, input exp_t y);
      return x.op == y.op && x.in1 == y.in1 && x.in2 == y.in2 && x.rd == y.rd &&
             x.rd_we == y.rd_we && x.illegal == y.illegal && x.pc == y.pc;
   endfunction

   task automatic chk_bundle(input string name, input exp_t got, input exp_t e);
      tests++;
      if (!same(got, e)) begin
         fails++;
         $display("FAIL %s: got op=%0d in1=%h in2=%h rd=%0d we=%0d ill=%0d pc=%h; want op=%0d in1=%h in2=%h rd=%0d we=%0d ill=%0d pc=%h",
                  name, got.op, got.in1, got.in2, got.rd, got.rd_we, got.illegal, got.pc,
                  e.op, e.in1, e.in2, e.rd, e.rd_we, e.illegal, e.pc);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Scoreboard push and model register-file update.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
         end else begin
            if (in_valid && in_ready)
               sb_q.push_back(model(in_instr, in_pc, read_model(in_instr[19:15]), read_model(in_instr[24:20])));
            if (wb_en && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
         end
      end
   end

   // Monitor: pops on consume, discards on flush/reset, checks stall stability.
   initial begin
      exp_t snap;
      exp_t e;
      bit stall_prev;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (stall_prev) chk_bundle("stall_stable", cur(), snap);
         if (out_valid) begin
            if (rst || flush) begin
               if (sb_q.size() == 0) chk("discard_nonempty", 32'd0, 32'd1);
               else void'(sb_q.pop_front());
            end else if (out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_bundle", 32'd0, 32'd1);
               end else begin
                  e = sb_q.pop_front();
                  chk_bundle("bundle", cur(), e);
               end
            end else begin
               chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
         end else begin
            chk("idle_pc", out_pc, RESET_PC);
         end
         stall_prev = out_valid && !out_ready && !rst && !flush;
         snap = cur();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [4:0] idx, input logic [31:0] data);
      wb_en = 1'b1; wb_rd = idx; wb_data = data;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      bit got;
      got = 1'b0;
      in_valid = 1'b1; in_instr = ins; in_pc = pc;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      chk("issue_accepted", 32'(got), 32'd1);
   endtask

   task automatic issue_chk(input string name, input logic [31:0] ins, input logic [31:0] pc,
                            input t_alu_op op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic we, input logic ill);
      exp_t e;
      e.op = op; e.in1 = a; e.in2 = b; e.rd = rd; e.rd_we = we; e.illegal = ill; e.pc = pc;
      issue(ins, pc);
      @(negedge clk);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk_bundle(name, cur(), e);
      tick();
   endtask

   function automatic logic [31:0] gen_instr();
      logic [6:0] f7;
      logic [6:0] opc;
      logic [31:0] w;
      case ($urandom_range(0, 2))
         0: f7 = F7_BASE;
         1: f7 = F7_ALT;
         default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 5))
         0:       opc = OPC_OP;
         1, 2:    opc = OPC_OP_IMM;
         3:       opc = OPC_LUI;
         4:       opc = OPC_AUIPC;
         default: opc = 7'($urandom);
      endcase
      w = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           5'($urandom_range(0, 7)), opc};
      return w;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_op", 32'(out_alu_op), 32'(ALU_ADD));
      chk("rst_in1", out_alu_in1, 32'd0);
      chk("rst_in2", out_alu_in2, 32'd0);
      chk("rst_rd_we", {26'd0, out_rd, out_rd_we}, 32'd0);
      chk("rst_illegal", 32'(out_illegal), 32'd0);
      chk("rst_pc", out_pc, RESET_PC);
      tick();

      wb(5'd1, 32'd10);
      wb(5'd2, 32'd5);
      issue_chk("add",   32'h002081B3, 32'h0,   ALU_ADD, 32'd10,  32'd5, 5'd3, 1'b1, 1'b0);
      issue_chk("sub",   32'h402081B3, 32'h4,   ALU_SUB, 32'd10,  32'd5, 5'd3, 1'b1, 1'b0);
      issue_chk("bad_f7",32'h022081B3, 32'h8,   ALU_ADD, 32'd0,   32'd0, 5'd3, 1'b0, 1'b1);
      issue_chk("srai",  32'h4020D213, 32'hC,   ALU_SRA, 32'd10,  32'd2, 5'd4, 1'b1, 1'b0);
      issue_chk("addi",  32'hFFF00213, 32'h10,  ALU_ADD, 32'd0,   32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
      issue_chk("auipc", 32'h12345297, 32'h100, ALU_ADD, 32'h100, 32'h1234_5000, 5'd5, 1'b1, 1'b0);

      // Back-to-back with a three-cycle stall.
      out_ready = 1'b0;
      issue(32'h002081B3, 32'h200);
      in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h204;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b2b_in_ready", 32'(in_ready), 32'd0);
         chk("b2b_held_pc", out_pc, 32'h200);
         tick();
      end
      out_ready = 1'b1;
      issue(32'h402081B3, 32'h204);
      @(negedge clk);
      chk("b2b_second_pc", out_pc, 32'h204);
      tick();

      // Flush while stalled with a new instruction offered.
      out_ready = 1'b0;
      issue(32'h00008313, 32'h300);
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h304; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(out_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("flush_no_accept", 32'(out_valid), 32'd0);
      tick();

      // Write-back in the accept cycle of a reader of x1.
      out_ready = 1'b1;
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
      issue(32'h00008313, 32'h400);
      wb_en = 1'b0;
      @(negedge clk);
`ifdef FORWARD_WB_EN
      chk("wb_same_cycle", out_alu_in1, 32'd7);
`else
      chk("wb_same_cycle", out_alu_in1, 32'd10);
`endif
      tick();
      issue_chk("wb_landed", 32'h00008313, 32'h404, ALU_ADD, 32'd7, 32'd0, 5'd6, 1'b1, 1'b0);

      // Reset while stalled.
      out_ready = 1'b0;
      issue(32'h002081B3, 32'h500);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_op", 32'(out_alu_op), 32'(ALU_ADD));
      chk("rst2_in1", out_alu_in1, 32'd0);
      chk("rst2_in2", out_alu_in2, 32'd0);
      chk("rst2_rd_we_ill", {25'd0, out_rd, out_rd_we, out_illegal}, 32'd0);
      chk("rst2_pc", out_pc, RESET_PC);
      tick();
      out_ready = 1'b1;
      issue_chk("rf_cleared", 32'h002081B3, 32'h600, ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0);

      // Randomized traffic against the scoreboard.
      for (int n = 0; n < 600; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_instr  = gen_instr();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         out_ready = ($urandom_range(0, 2) != 0);
         wb_en     = $urandom_range(0, 1) == 1;
         wb_rd     = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
